// File: rtl/bios_loader.sv
// bios_loader: boot-time copy engine that moves WORD_COUNT ROM words into RAM at DEST_BASE, then releases the CPU
// Ports: clk, rst_n (async assert, active-low); start_i copy request (taken only when idle or done);
//   rom_addr_o / rom_q_i  ROM read port, one-clock read latency;
//   ram_addr_o / ram_data_o / ram_we_o / ram_ready_i  RAM write port, write held until ram_ready_i;
//   busy_o copy in progress; done_o sticky completion; cpu_hold_o low once the first copy completes;
//   checksum_o running sum of written words.
// Optional feature macro BIOS_LOADER_CHECKSUM_EN builds the checksum accumulator; without it checksum_o is 0.
module bios_loader #(
  parameter int DATA_WIDTH     = 16,
  parameter int ROM_ADDR_WIDTH = 9,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int DEST_BASE      = 0,
  parameter int WORD_COUNT     = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0]     rom_q_i,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_data_o,
  output logic                      ram_we_o,
  input  logic                      ram_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      cpu_hold_o,
  output logic [DATA_WIDTH-1:0]     checksum_o
);
  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [ROM_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d, hold_q, hold_d;
  logic go, accept, last;
  assign go     = (state_q == IDLE || state_q == DONE) && start_i;
  assign accept = state_q == WRITE && ram_ready_i;
  assign last   = idx_q == ROM_ADDR_WIDTH'(WORD_COUNT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ram_addr_q <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ram_addr_q <= ram_addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start_i ? READ : state_q;
      READ:       state_d = LATCH;
      LATCH:      state_d = WRITE;
      WRITE:      state_d = !ram_ready_i ? WRITE : last ? DONE : READ;
      default:    state_d = IDLE;
    endcase
  end
  // idx doubles as the registered ROM address, so it is already stable for the READ edge
  always_comb begin
    idx_d      = go ? '0 : (accept && !last) ? idx_q + ROM_ADDR_WIDTH'(1) : idx_q;
    data_d     = state_q == LATCH ? rom_q_i : data_q;
    ram_addr_d = state_q == LATCH ? RAM_ADDR_WIDTH'(DEST_BASE) + RAM_ADDR_WIDTH'(idx_q) : ram_addr_q;
    we_d       = state_q == LATCH ? 1'b1 : accept ? 1'b0 : we_q;
    busy_d     = go ? 1'b1 : (accept && last) ? 1'b0 : busy_q;
    done_d     = go ? 1'b0 : (accept && last) ? 1'b1 : done_q;
    hold_d     = (accept && last) ? 1'b0 : hold_q;
  end
  assign rom_addr_o = idx_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = data_q;
  assign ram_we_o   = we_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cpu_hold_o = hold_q;
`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  assign sum_d = go ? '0 : accept ? sum_q + data_q : sum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign checksum_o = sum_q;
`else
  assign checksum_o = '0;
`endif
endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader: two loaders (base 0x0100 and wrapping base 0xFFFE) copied in lockstep against a transaction model
module tb_bios_loader;
`ifdef BIOS_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b1;
  always #5 clk = ~clk;
  logic [8:0] rom_addr [2];
  logic [15:0] rom_q [2], ram_addr [2], ram_data [2], csum [2];
  logic we [2], busy [2], done [2], hold [2];
  logic [15:0] rom_m [2][4] = '{'{16'h1111, 16'h2222, 16'h3333, 16'h4444},
                                '{16'h8000, 16'h8000, 16'h0001, 16'h0000}};
  logic [15:0] dest_m [2] = '{16'h0100, 16'hFFFE};
  logic [15:0] addr_b_lit [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [15:0] csum_lit [2] = '{16'hAAAA, 16'h0001};
  bit act_m [2], done_m [2], hold_m [2];
  int k_m [2];
  logic [15:0] sum_m [2];
  logic [15:0] wa [2][4], wd [2][4];
  int checks = 0, fails = 0, n;

  bios_loader #(.WORD_COUNT(4), .DEST_BASE(32'h0100)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .rom_addr_o(rom_addr[0]), .rom_q_i(rom_q[0]),
    .ram_addr_o(ram_addr[0]), .ram_data_o(ram_data[0]), .ram_we_o(we[0]), .ram_ready_i(ready),
    .busy_o(busy[0]), .done_o(done[0]), .cpu_hold_o(hold[0]), .checksum_o(csum[0]));
  bios_loader #(.WORD_COUNT(4), .DEST_BASE(32'hFFFE)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start), .rom_addr_o(rom_addr[1]), .rom_q_i(rom_q[1]),
    .ram_addr_o(ram_addr[1]), .ram_data_o(ram_data[1]), .ram_we_o(we[1]), .ram_ready_i(ready),
    .busy_o(busy[1]), .done_o(done[1]), .cpu_hold_o(hold[1]), .checksum_o(csum[1]));

  always @(posedge clk) begin
    rom_q[0] <= rom_m[0][rom_addr[0][1:0]];
    rom_q[1] <= rom_m[1][rom_addr[1][1:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transaction model: a copy is the ordered list of (dest+k, rom[k]) writes, one per accepted handshake
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act_m[i] = 0; done_m[i] = 0; hold_m[i] = 1; k_m[i] = 0; sum_m[i] = '0;
        chk("rst_we", we[i], 0);
        chk("rst_busy", busy[i], 0);
        chk("rst_done", done[i], 0);
        chk("rst_hold", hold[i], 1);
        chk("rst_ram_addr", ram_addr[i], 0);
        chk("rst_csum", csum[i], 0);
      end else begin
        chk("busy", busy[i], act_m[i]);
        chk("done", done[i], done_m[i]);
        chk("cpu_hold", hold[i], hold_m[i]);
        if (done_m[i]) chk("csum", csum[i], CS_EN ? sum_m[i] : 16'h0);
        if (we[i]) begin
          chk("we_in_copy", act_m[i] && k_m[i] < 4, 1);
          chk("wr_addr", ram_addr[i], 16'(dest_m[i] + 16'(k_m[i])));
          chk("wr_data", ram_data[i], rom_m[i][k_m[i][1:0]]);
        end
        if (act_m[i] && we[i] && ready) begin
          wa[i][k_m[i][1:0]] = ram_addr[i];
          wd[i][k_m[i][1:0]] = ram_data[i];
          sum_m[i] = sum_m[i] + ram_data[i];
          k_m[i]++;
          if (k_m[i] == 4) begin act_m[i] = 0; done_m[i] = 1; hold_m[i] = 0; end
        end else if (!act_m[i] && start) begin
          act_m[i] = 1; done_m[i] = 0; k_m[i] = 0; sum_m[i] = '0;
        end
      end
    end
  end

  initial begin
    repeat (3) tick;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rom_addr", rom_addr[i], 0);
      chk("rst_ram_data", ram_data[i], 0);
    end
    rst_n = 1'b1;
    repeat (2) tick;
    // plain copy
    start = 1'b1; tick; start = 1'b0; n = 0;
    while (!done[0] && n < 100) begin tick; n++; end
    chk("t1_cycles", n, 12);
    chk("t1_hold", hold[0], 0);
    chk("t1_busy", busy[0], 0);
    chk("t1_words", k_m[0], 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_addr_a", wa[0][k], 32'h0100 + k);
      chk("t1_data_a", wd[0][k], 32'h1111 * (k + 1));
      chk("t1_addr_b", wa[1][k], addr_b_lit[k]);
    end
    chk("t1_csum_a", csum[0], CS_EN ? csum_lit[0] : 16'h0);
    chk("t1_csum_b", csum[1], CS_EN ? csum_lit[1] : 16'h0);
    // restart from DONE with a 5-cycle stall on word 2
    start = 1'b1; tick; start = 1'b0; n = 0;
    chk("t2_done_drop", done[0], 0);
    chk("t2_hold_low", hold[0], 0);
    chk("t2_busy", busy[0], 1);
    while (!(we[0] && ram_addr[0] == 16'h0102) && n < 100) begin tick; n++; end
    chk("t2_reach", n, 8);
    ready = 1'b0;
    repeat (5) begin
      tick; n++;
      chk("t2_stall_we", we[0], 1);
      chk("t2_stall_addr", ram_addr[0], 16'h0102);
      chk("t2_stall_data", ram_data[0], 16'h3333);
    end
    ready = 1'b1;
    while (!done[0] && n < 100) begin tick; n++; end
    chk("t2_cycles", n, 17);
    chk("t2_words", k_m[0], 4);
    // start held through READ/LATCH/WRITE must not restart
    start = 1'b1; tick; n = 0;
    repeat (8) begin tick; n++; end
    start = 1'b0;
    while (!done[0] && n < 100) begin tick; n++; end
    chk("t3_cycles", n, 12);
    chk("t3_words", k_m[0], 4);
    // reset during a stalled WRITE of word 1
    start = 1'b1; tick; start = 1'b0; n = 0;
    while (!(we[0] && ram_addr[0] == 16'h0101) && n < 100) begin tick; n++; end
    chk("t4_reach", n, 5);
    ready = 1'b0; tick;
    rst_n = 1'b0; #1;
    chk("t4_we", we[0], 0);
    chk("t4_busy", busy[0], 0);
    chk("t4_hold", hold[0], 1);
    chk("t4_done", done[0], 0);
    tick; rst_n = 1'b1; ready = 1'b1;
    repeat (10) tick;
    chk("t4_idle_we", we[0], 0);
    chk("t4_idle_hold", hold[0], 1);
    start = 1'b1; tick; start = 1'b0; n = 0;
    while (!done[0] && n < 100) begin tick; n++; end
    chk("t5_cycles", n, 12);
    chk("t5_hold", hold[0], 0);
    chk("t5_csum_b", csum[1], CS_EN ? csum_lit[1] : 16'h0);
    repeat (2) tick;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/bios_loader.md
# bios_loader

Boot-time copy engine that reads a contiguous range of words from the synchronous BIOS ROM and writes them, in address order, into main RAM. It then releases the CPU from hold. It sits in the memory unit between the BIOS ROM read port and a RAM write port, and it drives the ROM address itself. The ROM read latency is one clock: data for an address registered on one clock edge is valid after the next edge.

## Interface
- DATA_WIDTH, 16, word width of ROM and RAM.
- ROM_ADDR_WIDTH, 9, ROM address width.
- RAM_ADDR_WIDTH, 16, RAM address width.
- DEST_BASE, 0, first RAM address written.
- WORD_COUNT, 512, number of words copied; legal range 1..2**ROM_ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  copy request, sampled only in IDLE and DONE.
- rom_addr  out  ROM_ADDR_WIDTH  registered ROM read address.
- rom_q  in  DATA_WIDTH  ROM registered read data.
- ram_addr  out  RAM_ADDR_WIDTH  registered RAM write address.
- ram_data  out  DATA_WIDTH  registered RAM write data.
- ram_we  out  1  write request; held until accepted.
- ram_ready  in  1  RAM accepts the write on an edge where ram_we=1 and ram_ready=1.
- busy  out  1  high from the start edge until the final write is accepted.
- done  out  1  sticky copy-complete flag.
- cpu_hold  out  1  holds the CPU in reset until the first copy completes.
- checksum  out  DATA_WIDTH  running sum of written words (see Configuration).

## Operation
- FSM states: IDLE, READ, LATCH, WRITE, DONE.
- Word index idx runs from 0 to WORD_COUNT-1 and is ROM_ADDR_WIDTH bits wide.
- IDLE: if start=1, set idx=0, rom_addr=0, busy=1, done=0, and go to READ.
- READ (1 cycle): rom_addr=idx is stable; the ROM captures it on this edge. Go to LATCH.
- LATCH (1 cycle): rom_q is valid. Capture:
  - data_reg <= rom_q
  - ram_addr <= DEST_BASE + idx, truncated to RAM_ADDR_WIDTH (wraps modulo 2**RAM_ADDR_WIDTH)
  - ram_we <= 1
  - Go to WRITE.
- WRITE: ram_we, ram_addr and ram_data stay constant until an edge with ram_ready=1.
  - On acceptance, ram_we <= 0.
  - If idx==WORD_COUNT-1, go to DONE: busy <= 0, done <= 1, cpu_hold <= 0.
  - Otherwise idx++, rom_addr <= idx+1, and go to READ.
- DONE: done stays 1 and cpu_hold stays 0. If start=1, restart exactly as from IDLE: done <= 0, busy <= 1. cpu_hold stays 0 on a restart.
- A start pulse in READ, LATCH or WRITE is ignored and is not queued.
- Exactly one RAM write is issued per word. No write is ever repeated or skipped.

## Timing
- Reset values: state=IDLE, rom_addr=0, ram_addr=0, ram_data=0, ram_we=0, busy=0, done=0, cpu_hold=1, checksum=0.
- Reset is asynchronous and takes effect mid-copy: outputs go to reset values immediately, with no further ram_we. A subsequent copy requires a new start.
- With ram_ready held at 1, each word takes 3 cycles (READ, LATCH, WRITE). Total: 3*WORD_COUNT cycles from the start edge to the edge that accepts the last write.
- done rises and cpu_hold falls on that edge; busy falls on the same edge.
- Each cycle of ram_ready=0 in WRITE adds one cycle. No output changes during the stall.
- WORD_COUNT=1 is legal: 3 cycles total.

## Configuration
- BIOS_LOADER_CHECKSUM_EN defined:
  - checksum is cleared on an accepted start.
  - On each accepted write, checksum <= checksum + ram_data, modulo 2**DATA_WIDTH.
  - checksum is valid whenever done=1 and holds until the next start or reset.
- Not defined: no accumulator is built, and checksum is tied to 0.

## Test plan
- WORD_COUNT=4, DEST_BASE=0x0100, ROM[0..3]=0x1111,0x2222,0x3333,0x4444, ram_ready=1, start pulse -> writes (0x0100,0x1111)…(0x0103,0x4444) in order; done=1 and cpu_hold=0 exactly 12 cycles after the start edge.
- Same setup, ram_ready=0 for 5 cycles during word 2 -> ram_we, ram_addr=0x0102 and ram_data=0x3333 stay stable; one write for that word; done after 17 cycles.
- start re-pulsed in READ/LATCH/WRITE -> no effect. start in DONE -> full second copy; done drops for the copy, cpu_hold stays 0.
- rst_n low during WRITE of word 1 -> ram_we=0, busy=0 and cpu_hold=1 immediately; no writes after release until start.
- DEST_BASE=0xFFFE, RAM_ADDR_WIDTH=16, WORD_COUNT=4 -> write addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- With BIOS_LOADER_CHECKSUM_EN, ROM words 0x8000, 0x8000, 0x0001 and WORD_COUNT=3 -> checksum=0x0001 at done. Without the macro, checksum=0.
